ghostbus_ext_arb: RTL and testbench

Two-requester arbiter and sequencer for a ghostbus-style external register/RAM interface (addr/wdata/rdata/we, fixed read latency). It sits between two masters and one external leaf such as a small register module: the host-side ghostbus decode path (port A) and a local fabric sequencer (port B). It serialises their accesses onto the single external bus. Exactly one transaction is in flight at any time.

---
 rtl/ghostbus_ext_arb_pkg.sv | 21 ++
 rtl/ghostbus_ext_arb_if.sv | 47 ++++
 rtl/ghostbus_ext_arb_pick2.sv | 29 ++
 rtl/ghostbus_ext_arb.sv | 129 ++++++++++++
 tb/tb_ghostbus_ext_arb.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ghostbus_ext_arb_pkg.sv
// Shared definitions for the ghostbus external-bus arbiter: FSM states, owner IDs
// and the read-latency counter width.
package ghostbus_ext_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RWAIT = 2'd2
    } arb_state_e;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam int unsigned CNT_W = 4;

    // The counter starts at RD_LAT-1 so that it expires in the cycle ext_rdata is valid.
    function automatic logic [CNT_W-1:0] rd_cnt_init(input int unsigned lat);
        return CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/ghostbus_ext_arb_if.sv
// Bundle of both requester ports plus the external leaf bus; the slave modport is
// the arbiter's view, the master modport is the requesters'/leaf's view.
interface ghostbus_ext_arb_if #(
    parameter int AW = 2,
    parameter int DW = 8
);
    logic          a_req;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic          a_gnt;
    logic [DW-1:0] a_rdata;
    logic          a_rvalid;

    logic          b_req;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic          b_gnt;
    logic [DW-1:0] b_rdata;
    logic          b_rvalid;

    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata;
    logic          ext_we;
    logic [DW-1:0] ext_rdata;
    logic          busy;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_rdata, a_rvalid,
        input  b_req, b_we, b_addr, b_wdata,
        output b_gnt, b_rdata, b_rvalid,
        output ext_addr, ext_wdata, ext_we, busy,
        input  ext_rdata
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_rdata, a_rvalid,
        output b_req, b_we, b_addr, b_wdata,
        input  b_gnt, b_rdata, b_rvalid,
        input  ext_addr, ext_wdata, ext_we, busy,
        output ext_rdata
    );

endinterface

// File: rtl/ghostbus_ext_arb_pick2.sv
// Combinational two-way pick between ports A and B.
// GHOSTBUS_ARB_FIXED_PRIO_EN selects fixed A-priority; otherwise round-robin on i_last.
module arb_pick2
    import ghostbus_ext_arb_pkg::*;
(
    input  logic i_a_req,
    input  logic i_b_req,
    input  logic i_last,
    output logic o_pick_a,
    output logic o_pick_b
);

`ifdef GHOSTBUS_ARB_FIXED_PRIO_EN
    logic w_unused_last;
    assign w_unused_last = i_last;

    always_comb begin
        o_pick_a = i_a_req;
        o_pick_b = i_b_req && !i_a_req;
    end
`else
    // On contention the port that was not granted last wins.
    always_comb begin
        o_pick_a = i_a_req && (!i_b_req || (i_last == PORT_B));
        o_pick_b = i_b_req && (!i_a_req || (i_last == PORT_A));
    end
`endif

endmodule

// File: rtl/ghostbus_ext_arb.sv
// Two-requester arbiter/sequencer onto one fixed-latency ghostbus external leaf.
// Arbitration mode is set by GHOSTBUS_ARB_FIXED_PRIO_EN (see arb_pick2).
module ghostbus_ext_arb
    import ghostbus_ext_arb_pkg::*;
#(
    parameter int AW     = 2,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    ghostbus_ext_arb_if.slave bus
);

    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    logic             r_owner;
    logic             r_we;
    logic             r_last;
    logic [AW-1:0]    r_addr;
    logic [DW-1:0]    r_wdata;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ext_we;
    logic             r_busy;
    logic [DW-1:0]    r_a_rdata;
    logic [DW-1:0]    r_b_rdata;
    logic             r_a_rvalid;
    logic             r_b_rvalid;

    logic w_pick_a;
    logic w_pick_b;
    logic w_gnt_a;
    logic w_gnt_b;
    logic w_grant;
    logic w_rd_done;

    arb_pick2 u_pick (
        .i_a_req  (bus.a_req),
        .i_b_req  (bus.b_req),
        .i_last   (r_last),
        .o_pick_a (w_pick_a),
        .o_pick_b (w_pick_b)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_a     = 1'b0;
        w_gnt_b     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!rst) begin
                    w_gnt_a = w_pick_a;
                    w_gnt_b = w_pick_b;
                    if (w_pick_a || w_pick_b) w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: w_state_nxt = r_we ? ST_IDLE : ST_RWAIT;
            ST_RWAIT: if (r_cnt == '0) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_grant   = w_gnt_a || w_gnt_b;
    assign w_rd_done = (r_state == ST_RWAIT) && (r_cnt == '0);

    // Bus fields are loaded at grant so ext_* are already valid in the ISSUE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner    <= PORT_A;
            r_we       <= 1'b0;
            r_last     <= PORT_B;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_cnt      <= '0;
            r_ext_we   <= 1'b0;
            r_busy     <= 1'b0;
            r_a_rdata  <= '0;
            r_b_rdata  <= '0;
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
        end else begin
            r_ext_we   <= 1'b0;
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
            r_busy     <= (w_state_nxt != ST_IDLE);

            if (w_grant) begin
                r_owner  <= w_gnt_b ? PORT_B : PORT_A;
                r_last   <= w_gnt_b ? PORT_B : PORT_A;
                r_we     <= w_gnt_b ? bus.b_we    : bus.a_we;
                r_addr   <= w_gnt_b ? bus.b_addr  : bus.a_addr;
                r_wdata  <= w_gnt_b ? bus.b_wdata : bus.a_wdata;
                r_ext_we <= w_gnt_b ? bus.b_we    : bus.a_we;
            end

            if ((r_state == ST_ISSUE) && !r_we)
                r_cnt <= rd_cnt_init(RD_LAT);
            else if ((r_state == ST_RWAIT) && (r_cnt != '0))
                r_cnt <= r_cnt - CNT_W'(1);

            if (w_rd_done) begin
                if (r_owner == PORT_B) begin
                    r_b_rdata  <= bus.ext_rdata;
                    r_b_rvalid <= 1'b1;
                end else begin
                    r_a_rdata  <= bus.ext_rdata;
                    r_a_rvalid <= 1'b1;
                end
            end
        end
    end

    assign bus.a_gnt     = w_gnt_a;
    assign bus.b_gnt     = w_gnt_b;
    assign bus.a_rdata   = r_a_rdata;
    assign bus.b_rdata   = r_b_rdata;
    assign bus.a_rvalid  = r_a_rvalid;
    assign bus.b_rvalid  = r_b_rvalid;
    assign bus.ext_addr  = r_addr;
    assign bus.ext_wdata = r_wdata;
    assign bus.ext_we    = r_ext_we;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_ghostbus_ext_arb.sv
// Scoreboard bench for ghostbus_ext_arb: one instance with RD_LAT=1, one with RD_LAT=4,
// each attached to a small registered-read leaf memory.
module tb_ghostbus_ext_arb;

    localparam int PA = 0;
    localparam int PB = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    ghostbus_ext_arb_if #(.AW(2), .DW(8)) bus1 ();
    ghostbus_ext_arb_if #(.AW(2), .DW(8)) bus4 ();

    ghostbus_ext_arb #(.AW(2), .DW(8), .RD_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    ghostbus_ext_arb #(.AW(2), .DW(8), .RD_LAT(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

    logic [7:0] mem1 [4] = '{8'h00, 8'h3C, 8'h00, 8'h99};
    logic [7:0] mem4 [4] = '{8'h5E, 8'h00, 8'h00, 8'hC7};

    always @(posedge clk) begin
        if (bus1.ext_we) mem1[bus1.ext_addr] <= bus1.ext_wdata;
        bus1.ext_rdata <= mem1[bus1.ext_addr];
        bus4.ext_rdata <= mem4[bus4.ext_addr];
    end

    typedef struct {
        int port;
        int data;
        int addr;
        int t;
    } ev_t;

    ev_t gq1[$];
    ev_t wq1[$];
    ev_t rq1[$];
    ev_t gq4[$];
    ev_t rq4[$];

    function automatic ev_t mk(input int p, input int d, input int a, input int tt);
        ev_t e;
        e.port = p;
        e.data = d;
        e.addr = a;
        e.t    = tt;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int enc(input logic a, input logic b);
        if (a && !b) return PA;
        if (b && !a) return PB;
        return 2;
    endfunction

    always @(negedge clk) begin : monitor
        ev_t e;
        if (bus1.a_gnt || bus1.b_gnt) begin
            chk("gnt1_pending", int'(gq1.size() > 0), 1);
            if (gq1.size() > 0) begin
                e = gq1.pop_front();
                chk("gnt1_port", enc(bus1.a_gnt, bus1.b_gnt), e.port);
                chk("gnt1_cycle", cyc, e.t);
            end
        end
        if (bus1.ext_we) begin
            chk("ext1_pending", int'(wq1.size() > 0), 1);
            if (wq1.size() > 0) begin
                e = wq1.pop_front();
                chk("ext1_addr", int'(bus1.ext_addr), e.addr);
                chk("ext1_wdata", int'(bus1.ext_wdata), e.data);
                chk("ext1_cycle", cyc, e.t);
            end
        end
        if (bus1.a_rvalid || bus1.b_rvalid) begin
            chk("rv1_pending", int'(rq1.size() > 0), 1);
            if (rq1.size() > 0) begin
                e = rq1.pop_front();
                chk("rv1_port", enc(bus1.a_rvalid, bus1.b_rvalid), e.port);
                chk("rv1_rdata", int'(bus1.b_rvalid ? bus1.b_rdata : bus1.a_rdata), e.data);
                chk("rv1_cycle", cyc, e.t);
            end
        end
        if (bus4.a_gnt || bus4.b_gnt) begin
            chk("gnt4_pending", int'(gq4.size() > 0), 1);
            if (gq4.size() > 0) begin
                e = gq4.pop_front();
                chk("gnt4_port", enc(bus4.a_gnt, bus4.b_gnt), e.port);
                chk("gnt4_cycle", cyc, e.t);
            end
        end
        if (bus4.a_rvalid || bus4.b_rvalid) begin
            chk("rv4_pending", int'(rq4.size() > 0), 1);
            if (rq4.size() > 0) begin
                e = rq4.pop_front();
                chk("rv4_port", enc(bus4.a_rvalid, bus4.b_rvalid), e.port);
                chk("rv4_rdata", int'(bus4.b_rvalid ? bus4.b_rdata : bus4.a_rdata), e.data);
                chk("rv4_cycle", cyc, e.t);
            end
        end
        if (bus4.ext_we) chk("ext4_no_write", int'(bus4.ext_we), 0);
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t;
        bus1.a_req = 1'b1; bus1.a_we = 1'b0; bus1.a_addr = 2'd0; bus1.a_wdata = 8'h00;
        bus1.b_req = 1'b0; bus1.b_we = 1'b0; bus1.b_addr = 2'd0; bus1.b_wdata = 8'h00;
        bus4.a_req = 1'b0; bus4.a_we = 1'b0; bus4.a_addr = 2'd0; bus4.a_wdata = 8'h00;
        bus4.b_req = 1'b0; bus4.b_we = 1'b0; bus4.b_addr = 2'd0; bus4.b_wdata = 8'h00;

        // Reset with A requesting: no grant while rst is high.
        repeat (3) nxt();
        @(negedge clk);
        chk("rst_a_gnt", int'(bus1.a_gnt), 0);
        chk("rst_ext_addr", int'(bus1.ext_addr), 0);
        chk("rst_ext_wdata", int'(bus1.ext_wdata), 0);
        chk("rst_ext_we", int'(bus1.ext_we), 0);
        chk("rst_busy", int'(bus1.busy), 0);
        chk("rst_a_rdata", int'(bus1.a_rdata), 0);
        chk("rst_b_rdata", int'(bus1.b_rdata), 0);
        chk("rst_rvalid", int'(bus1.a_rvalid | bus1.b_rvalid), 0);
        nxt();
        rst = 1'b0;
        bus1.a_req = 1'b0;

        // A writes 0xA5 to addr 2.
        nxt(); t = cyc;
        gq1.push_back(mk(PA, 0, 0, t));
        wq1.push_back(mk(0, 8'hA5, 2, t + 1));
        bus1.a_req = 1'b1; bus1.a_we = 1'b1; bus1.a_addr = 2'd2; bus1.a_wdata = 8'hA5;
        nxt(); bus1.a_req = 1'b0;
        @(negedge clk); chk("wr_busy_issue", int'(bus1.busy), 1);
        nxt();
        @(negedge clk); chk("wr_busy_done", int'(bus1.busy), 0);

        // B reads addr 1 (leaf holds 0x3C).
        nxt(); t = cyc;
        gq1.push_back(mk(PB, 0, 0, t));
        rq1.push_back(mk(PB, 8'h3C, 0, t + 3));
        bus1.b_req = 1'b1; bus1.b_we = 1'b0; bus1.b_addr = 2'd1;
        nxt(); bus1.b_req = 1'b0;
        repeat (3) nxt();
        @(negedge clk);
        chk("rd_b_rdata_hold", int'(bus1.b_rdata), 8'h3C);
        chk("rd_a_rdata_untouched", int'(bus1.a_rdata), 0);

        // Continuous contention with writes.
        nxt(); t = cyc;
        bus1.a_we = 1'b1; bus1.a_addr = 2'd0; bus1.a_wdata = 8'h11;
        bus1.b_we = 1'b1; bus1.b_addr = 2'd3; bus1.b_wdata = 8'h22;
        for (int k = 0; k < 4; k++) begin
`ifdef GHOSTBUS_ARB_FIXED_PRIO_EN
            gq1.push_back(mk(PA, 0, 0, t + 2 * k));
            wq1.push_back(mk(0, 8'h11, 0, t + 2 * k + 1));
`else
            if (k % 2 == 0) begin
                gq1.push_back(mk(PA, 0, 0, t + 2 * k));
                wq1.push_back(mk(0, 8'h11, 0, t + 2 * k + 1));
            end else begin
                gq1.push_back(mk(PB, 0, 0, t + 2 * k));
                wq1.push_back(mk(0, 8'h22, 3, t + 2 * k + 1));
            end
`endif
        end
        bus1.a_req = 1'b1; bus1.b_req = 1'b1;
        repeat (7) nxt();
        bus1.a_req = 1'b0; bus1.b_req = 1'b0;
        nxt();

        // B reads addr 0; A raises and drops a request while B's read is in flight.
        nxt(); t = cyc;
        gq1.push_back(mk(PB, 0, 0, t));
        rq1.push_back(mk(PB, 8'h11, 0, t + 3));
        bus1.b_req = 1'b1; bus1.b_we = 1'b0; bus1.b_addr = 2'd0;
        nxt(); bus1.b_req = 1'b0;
        bus1.a_req = 1'b1; bus1.a_we = 1'b0; bus1.a_addr = 2'd2;
        nxt(); bus1.a_req = 1'b0;
        repeat (2) nxt();

        // Reset during RWAIT abandons B's read.
        nxt(); t = cyc;
        gq1.push_back(mk(PB, 0, 0, t));
        bus1.b_req = 1'b1; bus1.b_we = 1'b0; bus1.b_addr = 2'd3;
        nxt(); bus1.b_req = 1'b0;
        nxt(); rst = 1'b1;
        nxt(); rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_ext_addr", int'(bus1.ext_addr), 0);
        chk("mid_rst_ext_wdata", int'(bus1.ext_wdata), 0);
        chk("mid_rst_ext_we", int'(bus1.ext_we), 0);
        chk("mid_rst_busy", int'(bus1.busy), 0);
        chk("mid_rst_b_rdata", int'(bus1.b_rdata), 0);
        chk("mid_rst_a_rdata", int'(bus1.a_rdata), 0);
        nxt(); t = cyc;
        gq1.push_back(mk(PA, 0, 0, t));
        wq1.push_back(mk(0, 8'h5A, 1, t + 1));
        bus1.a_req = 1'b1; bus1.a_we = 1'b1; bus1.a_addr = 2'd1; bus1.a_wdata = 8'h5A;
        nxt(); bus1.a_req = 1'b0;
        nxt(); t = cyc;
        gq1.push_back(mk(PA, 0, 0, t));
        rq1.push_back(mk(PA, 8'h5A, 0, t + 3));
        bus1.a_req = 1'b1; bus1.a_we = 1'b0; bus1.a_addr = 2'd1;
        nxt(); bus1.a_req = 1'b0;
        repeat (3) nxt();

        // RD_LAT=4: A reads addr 3 while B waits for the next grant slot.
        nxt(); t = cyc;
        gq4.push_back(mk(PA, 0, 0, t));
        rq4.push_back(mk(PA, 8'hC7, 0, t + 6));
        bus4.a_req = 1'b1; bus4.a_we = 1'b0; bus4.a_addr = 2'd3;
        nxt(); bus4.a_req = 1'b0;
        gq4.push_back(mk(PB, 0, 0, t + 6));
        rq4.push_back(mk(PB, 8'h5E, 0, t + 12));
        bus4.b_req = 1'b1; bus4.b_we = 1'b0; bus4.b_addr = 2'd0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("lat4_ext_addr", int'(bus4.ext_addr), 3);
            chk("lat4_busy", int'(bus4.busy), 1);
            nxt();
        end
        nxt(); bus4.b_req = 1'b0;
        repeat (6) nxt();

        @(negedge clk);
        chk("drain_gnt1", gq1.size(), 0);
        chk("drain_ext1", wq1.size(), 0);
        chk("drain_rv1", rq1.size(), 0);
        chk("drain_gnt4", gq4.size(), 0);
        chk("drain_rv4", rq4.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
